// File: rtl/filter_frame_ctrl.sv
// Single-frame capture sequencer: waits for a frame start on the filtered stream,
// writes one frame of thresholded edge bits to the frame buffer and counts edge pixels.
module filter_frame_ctrl #(
  parameter int H_RES   = 170,
  parameter int V_RES   = 240,
  parameter int ADDR_W  = 16,
  parameter int EDGE_TH = 128,
  parameter int WIDTH   = 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic              i_f_vsync,
  input  logic              i_f_de,
  input  logic [WIDTH-1:0]  i_f_data,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic              o_wr_en,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic              o_wr_data,
  output logic [ADDR_W:0]   o_edge_cnt
);

  localparam logic [ADDR_W:0]  FRAME_PIX = (ADDR_W+1)'(H_RES * V_RES);
  localparam logic [ADDR_W:0]  LAST_PIX  = FRAME_PIX - {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]  ONE_CNT   = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] EDGE_TH_V = WIDTH'(EDGE_TH);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT_VS = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic                vsync_q;
  logic [ADDR_W:0]     pix_cnt_q, pix_cnt_d;
  logic [ADDR_W:0]     edge_cnt_q, edge_cnt_d;
  logic                err_q, err_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic                wr_data_q, wr_data_d;
  logic                vs_rise_s;
  logic                pix_edge_s;
  logic                last_pix_s;

  assign vs_rise_s  = i_f_vsync & ~vsync_q;
  assign pix_edge_s = (i_f_data >= EDGE_TH_V);
  assign last_pix_s = (pix_cnt_q == LAST_PIX);

  // Next-state and output decode; abort outranks everything, the final pixel outranks a short-frame vsync
  always_comb begin
    state_d    = state_q;
    pix_cnt_d  = pix_cnt_q;
    edge_cnt_d = edge_cnt_q;
    err_d      = err_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          state_d    = S_WAIT_VS;
          pix_cnt_d  = {(ADDR_W+1){1'b0}};
          edge_cnt_d = {(ADDR_W+1){1'b0}};
          err_d      = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT_VS: begin
        if (i_abort) begin
          state_d = S_IDLE;
        end else if (vs_rise_s) begin
          state_d = S_CAPTURE;
        end else begin
          state_d = S_WAIT_VS;
        end
      end
      S_CAPTURE: begin
        if (i_abort) begin
          state_d = S_IDLE;
        end else if (i_f_de && (last_pix_s || !vs_rise_s)) begin
          wr_en_d    = 1'b1;
          wr_addr_d  = pix_cnt_q[ADDR_W-1:0];
          wr_data_d  = pix_edge_s;
          pix_cnt_d  = pix_cnt_q + ONE_CNT;
          edge_cnt_d = edge_cnt_q + {{ADDR_W{1'b0}}, pix_edge_s};
          if (last_pix_s) begin
            state_d = S_DONE;
          end else begin
            state_d = S_CAPTURE;
          end
        end else if (vs_rise_s) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end else begin
          state_d = S_CAPTURE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d == S_WAIT_VS) || (state_d == S_CAPTURE);
    done_d = (state_d == S_DONE);
  end

  // State, counters and registered outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      vsync_q    <= 1'b0;
      pix_cnt_q  <= {(ADDR_W+1){1'b0}};
      edge_cnt_q <= {(ADDR_W+1){1'b0}};
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= {ADDR_W{1'b0}};
      wr_data_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      vsync_q    <= i_f_vsync;
      pix_cnt_q  <= pix_cnt_d;
      edge_cnt_q <= edge_cnt_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  assign o_busy     = busy_q;
  assign o_done     = done_q;
  assign o_err      = err_q;
  assign o_wr_en    = wr_en_q;
  assign o_wr_addr  = wr_addr_q;
  assign o_wr_data  = wr_data_q;
  assign o_edge_cnt = edge_cnt_q;

endmodule

// File: tb/tb_filter_frame_ctrl.sv
// Directed bench for filter_frame_ctrl on a 4x3 frame: a queue of expected writes
// plus a running edge count form the model, checked every cycle.
module tb_filter_frame_ctrl;
  localparam int H  = 4;
  localparam int V  = 3;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          i_start = 1'b0;
  logic          i_abort = 1'b0;
  logic          i_f_vsync = 1'b0;
  logic          i_f_de = 1'b0;
  logic [7:0]    i_f_data = 8'd0;
  logic          o_busy, o_done, o_err, o_wr_en, o_wr_data;
  logic [AW-1:0] o_wr_addr;
  logic [AW:0]   o_edge_cnt;

  filter_frame_ctrl #(.H_RES(H), .V_RES(V), .ADDR_W(AW), .EDGE_TH(128), .WIDTH(8)) dut (
    .clk(clk), .rstn(rstn), .i_start(i_start), .i_abort(i_abort),
    .i_f_vsync(i_f_vsync), .i_f_de(i_f_de), .i_f_data(i_f_data),
    .o_busy(o_busy), .o_done(o_done), .o_err(o_err), .o_wr_en(o_wr_en),
    .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data), .o_edge_cnt(o_edge_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {int addr; int bit_v;} wr_t;
  wr_t exp_q[$];
  wr_t head;
  int  n_total = 0;
  int  n_pass = 0;
  int  model_edges = 0;
  int  next_addr = 0;

  task automatic chk(input string name, input int act, input int expv);
    n_total++;
    if (act == expv) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, expv);
  endtask

  function automatic int edge_of(input int v);
    return (v >= 128) ? 1 : 0;
  endfunction

  // Every cycle: each write must match the next expected one, and the edge count must track the writes
  always @(negedge clk) begin
    if (o_wr_en) begin
      if (exp_q.size() > 0) begin
        head = exp_q.pop_front();
        chk("wr_addr", int'(o_wr_addr), head.addr);
        chk("wr_data", int'(o_wr_data), head.bit_v);
        model_edges += head.bit_v;
      end else begin
        chk("unexpected_wr", int'(o_wr_en), 0);
      end
    end
    chk("edge_cnt", int'(o_edge_cnt), model_edges);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    i_f_de = 1'b0;
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic start_cap();
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    model_edges = 0;
    next_addr = 0;
  endtask

  task automatic vs_pulse();
    i_f_vsync = 1'b1;
    step();
    i_f_vsync = 1'b0;
  endtask

  task automatic pix(input int v, input bit wr);
    i_f_de = 1'b1;
    i_f_data = 8'(v);
    if (wr) begin
      exp_q.push_back('{next_addr, edge_of(v)});
      next_addr++;
    end
    step();
  endtask

  initial begin
    #20;
    chk("rst_busy", int'(o_busy), 0);
    chk("rst_done", int'(o_done), 0);
    chk("rst_err", int'(o_err), 0);
    chk("rst_wr_en", int'(o_wr_en), 0);
    chk("rst_addr", int'(o_wr_addr), 0);
    #3 rstn = 1'b1;
    step();

    // normal frame, alternating 200/10
    start_cap();
    chk("s1_busy_wait", int'(o_busy), 1);
    vs_pulse();
    for (int i = 0; i < 12; i++) pix((i % 2 == 0) ? 200 : 10, 1'b1);
    chk("s1_done", int'(o_done), 1);
    chk("s1_busy_low", int'(o_busy), 0);
    chk("s1_edge6", int'(o_edge_cnt), 6);
    idle(1);
    chk("s1_done_pulse", int'(o_done), 0);
    chk("s1_q_empty", exp_q.size(), 0);

    // de before frame start is ignored, including de in the vsync-rise cycle
    start_cap();
    for (int i = 0; i < 5; i++) pix(200, 1'b0);
    i_f_vsync = 1'b1;
    pix(200, 1'b0);
    i_f_vsync = 1'b0;
    for (int i = 0; i < 12; i++) pix(i * 20, 1'b1);
    chk("s2_done", int'(o_done), 1);
    chk("s2_edge5", int'(o_edge_cnt), 5);
    for (int i = 0; i < 3; i++) pix(200, 1'b0);
    idle(1);
    chk("s2_q_empty", exp_q.size(), 0);

    // short frame after 7 pixels
    start_cap();
    vs_pulse();
    for (int i = 0; i < 7; i++) pix(200, 1'b1);
    i_f_vsync = 1'b1;
    pix(200, 1'b0);
    i_f_vsync = 1'b0;
    chk("s3_err", int'(o_err), 1);
    chk("s3_busy", int'(o_busy), 0);
    chk("s3_no_done", int'(o_done), 0);
    idle(3);
    chk("s3_err_sticky", int'(o_err), 1);
    chk("s3_edge7", int'(o_edge_cnt), 7);
    start_cap();
    chk("s3_err_clr", int'(o_err), 0);
    chk("s3_busy_again", int'(o_busy), 1);
    i_abort = 1'b1;
    step();
    i_abort = 1'b0;
    chk("s3_abort_wait", int'(o_busy), 0);

    // completion coincides with vsync rise
    start_cap();
    vs_pulse();
    for (int i = 0; i < 11; i++) pix((i % 2 == 0) ? 10 : 200, 1'b1);
    i_f_vsync = 1'b1;
    pix(200, 1'b1);
    i_f_vsync = 1'b0;
    chk("s4_done", int'(o_done), 1);
    chk("s4_no_err", int'(o_err), 0);
    chk("s4_edge6", int'(o_edge_cnt), 6);
    idle(2);

    // abort together with pixel 5
    start_cap();
    vs_pulse();
    for (int i = 0; i < 4; i++) pix(200, 1'b1);
    i_abort = 1'b1;
    pix(200, 1'b0);
    i_abort = 1'b0;
    chk("s5_busy", int'(o_busy), 0);
    chk("s5_no_done", int'(o_done), 0);
    chk("s5_err", int'(o_err), 0);
    for (int i = 0; i < 3; i++) pix(200, 1'b0);
    i_f_vsync = 1'b1;
    pix(200, 1'b0);
    i_f_vsync = 1'b0;
    for (int i = 0; i < 3; i++) pix(200, 1'b0);
    idle(2);
    chk("s5_still_idle", int'(o_busy), 0);
    chk("s5_edge_hold", int'(o_edge_cnt), 4);

    // start during capture is ignored
    start_cap();
    vs_pulse();
    pix(200, 1'b1);
    pix(10, 1'b1);
    pix(200, 1'b1);
    i_start = 1'b1;
    pix(10, 1'b1);
    i_start = 1'b0;
    for (int i = 0; i < 8; i++) pix(200, 1'b1);
    chk("s6_done", int'(o_done), 1);
    chk("s6_edge10", int'(o_edge_cnt), 10);
    idle(2);

    // asynchronous reset mid-capture
    start_cap();
    vs_pulse();
    for (int i = 0; i < 3; i++) pix(200, 1'b1);
    idle(1);
    chk("s7_busy_pre", int'(o_busy), 1);
    #2 rstn = 1'b0;
    #1;
    chk("s7_busy_rst", int'(o_busy), 0);
    chk("s7_edge_rst", int'(o_edge_cnt), 0);
    chk("s7_addr_rst", int'(o_wr_addr), 0);
    chk("s7_data_rst", int'(o_wr_data), 0);
    chk("s7_err_rst", int'(o_err), 0);
    model_edges = 0;
    exp_q.delete();
    #4 rstn = 1'b1;
    for (int i = 0; i < 3; i++) pix(200, 1'b0);
    idle(1);
    chk("s7_idle_after", int'(o_busy), 0);
    chk("final_q_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
